// File: rtl/bus_group_arbiter.sv
// Round-robin arbiter sharing one slave valid/ready/data/resp/mreq channel
// between N_MST masters, with bounded lock tenures for back-to-back transfers.
module bus_group_arbiter #(
    parameter int N_MST    = 2,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [N_MST-1:0]      i_m_valid,
    input  logic [N_MST*DW-1:0]   i_m_data,
    input  logic [N_MST-1:0]      i_m_mreq,
    output logic [N_MST-1:0]      o_m_ready,
    output logic [DW-1:0]         o_m_data,
    output logic [N_MST-1:0]      o_m_resp,
    output logic                  o_s_valid,
    input  logic                  i_s_ready,
    output logic [DW-1:0]         o_s_data,
    input  logic [DW-1:0]         i_s_data,
    input  logic                  i_s_resp,
    output logic                  o_s_mreq,
    output logic [N_MST-1:0]      o_grant,
    output logic                  o_busy
);

    localparam int IW  = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int LCW = $clog2(MAX_LOCK) + 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    r_last, w_last_nxt;
    logic [LCW-1:0]   r_lock_cnt, w_lock_cnt_nxt;
    logic [N_MST-1:0] r_grant, w_grant_nxt;

    logic [IW-1:0]    w_winner;
    logic             w_found;
    logic             w_own_valid;
    logic             w_own_mreq;
    logic             w_hs;
    logic [DW-1:0]    w_data_arr [N_MST];

    for (genvar k = 0; k < N_MST; k++) begin : g_slice
        assign w_data_arr[k] = i_m_data[k*DW +: DW];
    end

    // Round-robin scan: first requester strictly after the last owner, wrapping.
    always_comb begin
        int            idx_int;
        logic [IW-1:0] idx;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an untaken path holds its old value and infers a latch.
        idx_int  = 0;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = r_last;
        for (int i = 1; i <= N_MST; i++) begin
            idx_int = (int'(r_last) + i) % N_MST;
            idx     = IW'(idx_int);
            if (!w_found && i_m_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    assign w_own_valid = i_m_valid[r_owner];
    assign w_own_mreq  = i_m_mreq[r_owner];

    always_comb begin
        o_s_valid      = 1'b0;
        o_s_data       = '0;
        o_s_mreq       = 1'b0;
        o_m_ready      = '0;
        o_m_resp       = '0;
        w_hs           = 1'b0;
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_lock_cnt_nxt = r_lock_cnt;
        w_grant_nxt    = r_grant;

        case (r_state)
            ARB: begin
                if (w_found) begin
                    w_state_nxt           = BUSY;
                    w_owner_nxt           = w_winner;
                    w_grant_nxt           = '0;
                    w_grant_nxt[w_winner] = 1'b1;
                    w_lock_cnt_nxt        = '0;
                end
            end
            BUSY: begin
                o_s_valid          = w_own_valid;
                o_s_data           = w_data_arr[r_owner];
                o_s_mreq           = w_own_mreq && (r_lock_cnt < LOCK_LAST);
                o_m_ready[r_owner] = i_s_ready;
                o_m_resp[r_owner]  = i_s_resp && i_s_ready && w_own_valid;
                w_hs               = w_own_valid && i_s_ready;

                if (w_hs && o_s_mreq) begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end else if (w_hs || !w_own_valid) begin
                    // Tenure ends on an unlocked/final beat or when the owner goes idle.
                    w_state_nxt = ARB;
                    w_last_nxt  = r_owner;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_last     <= IW'(N_MST - 1);
            r_lock_cnt <= '0;
            r_grant    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

    assign o_m_data = i_s_data;
    assign o_grant  = r_grant;
    assign o_busy   = (r_state == BUSY);

endmodule

// File: tb/tb_bus_group_arbiter.sv
// Directed-vector bench for bus_group_arbiter (N_MST=2, MAX_LOCK=4) plus
// hand-written reset sequences and a MAX_LOCK=1 instance for the no-lock case.
module tb_bus_group_arbiter;

    localparam int DW = 32;
    localparam logic [31:0] D0 = 32'hA5A5_0001;
    localparam logic [31:0] D1 = 32'hB5B5_0002;

    logic          clk;
    logic          rstn;
    logic [1:0]    m_valid;
    logic [63:0]   m_data;
    logic [1:0]    m_mreq;
    logic [1:0]    m_ready;
    logic [31:0]   m_rdata;
    logic [1:0]    m_resp;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic [31:0]   s_rdata;
    logic          s_resp;
    logic          s_mreq;
    logic [1:0]    grant;
    logic          busy;

    logic [1:0]    l1_m_ready, l1_m_resp, l1_grant;
    logic [31:0]   l1_m_rdata, l1_s_data;
    logic          l1_s_valid, l1_s_mreq, l1_busy;

    int checks = 0;
    int errors = 0;

    bus_group_arbiter #(.N_MST(2), .DW(DW), .MAX_LOCK(4)) u_dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_m_valid(m_valid), .i_m_data(m_data), .i_m_mreq(m_mreq),
        .o_m_ready(m_ready), .o_m_data(m_rdata), .o_m_resp(m_resp),
        .o_s_valid(s_valid), .i_s_ready(s_ready), .o_s_data(s_data),
        .i_s_data(s_rdata), .i_s_resp(s_resp), .o_s_mreq(s_mreq),
        .o_grant(grant), .o_busy(busy)
    );

    bus_group_arbiter #(.N_MST(2), .DW(DW), .MAX_LOCK(1)) u_dut_l1 (
        .i_clk(clk), .i_rstn(rstn),
        .i_m_valid(m_valid), .i_m_data(m_data), .i_m_mreq(m_mreq),
        .o_m_ready(l1_m_ready), .o_m_data(l1_m_rdata), .o_m_resp(l1_m_resp),
        .o_s_valid(l1_s_valid), .i_s_ready(s_ready), .o_s_data(l1_s_data),
        .i_s_data(s_rdata), .i_s_resp(s_resp), .o_s_mreq(l1_s_mreq),
        .o_grant(l1_grant), .o_busy(l1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  mreq;
        logic        ready;
        logic        resp;
        logic [31:0] rdata;
        logic [1:0]  e_grant;
        logic        e_busy;
        logic        e_s_valid;
        logic [1:0]  e_m_ready;
        logic [1:0]  e_m_resp;
        logic        e_s_mreq;
        logic [31:0] e_s_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] mreq,
                                input logic ready, input logic resp, input logic [31:0] rdata,
                                input logic [1:0] g, input logic b, input logic sv,
                                input logic [1:0] mr, input logic [1:0] rs,
                                input logic sm, input logic [31:0] sd);
        vec_t v;
        v.valid = valid; v.mreq = mreq; v.ready = ready; v.resp = resp; v.rdata = rdata;
        v.e_grant = g; v.e_busy = b; v.e_s_valid = sv; v.e_m_ready = mr;
        v.e_m_resp = rs; v.e_s_mreq = sm; v.e_s_data = sd;
        return v;
    endfunction

    initial begin
        // Fields: valid mreq ready resp rdata | grant busy s_valid m_ready m_resp s_mreq s_data
        // First grant then round-robin alternation, unlocked, slave always ready.
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 1, 32'h0000_1111, 2'b01, 1, 1, 2'b01, 2'b01, 0, D0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b10, 1, 1, 2'b10, 2'b00, 0, D1));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b01, 1, 1, 2'b01, 2'b00, 0, D0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b10, 1, 1, 2'b10, 2'b00, 0, D1));
        // m0 locked: four back-to-back beats, mreq high on beats 1-3 only.
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 32'h0,         2'b01, 1, 1, 2'b01, 2'b00, 1, D0));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 32'h0,         2'b01, 1, 1, 2'b01, 2'b00, 1, D0));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 32'h0,         2'b01, 1, 1, 2'b01, 2'b00, 1, D0));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 32'h0,         2'b01, 1, 1, 2'b01, 2'b00, 0, D0));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 32'h0,         2'b10, 1, 1, 2'b10, 2'b00, 0, D1));
        // m1 granted, slave stalls five cycles, then one transfer with response.
        vecs.push_back(mk(2'b10, 2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(2'b10, 2'b00, 0, 1, 32'hDEAD_0000, 2'b10, 1, 1, 2'b00, 2'b00, 0, D1));
        vecs.push_back(mk(2'b10, 2'b00, 1, 1, 32'h1234_5678, 2'b10, 1, 1, 2'b10, 2'b10, 0, D1));
        vecs.push_back(mk(2'b00, 2'b00, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        // m0 granted then withdraws before ready; m1 must win next.
        vecs.push_back(mk(2'b01, 2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b01, 2'b00, 0, 0, 32'h0,         2'b01, 1, 1, 2'b00, 2'b00, 0, D0));
        vecs.push_back(mk(2'b10, 2'b00, 0, 0, 32'h0,         2'b01, 1, 0, 2'b00, 2'b00, 0, D0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 32'h0,         2'b10, 1, 1, 2'b10, 2'b00, 0, D1));
        vecs.push_back(mk(2'b01, 2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0));

        rstn    = 1'b0;
        m_valid = '0;
        m_mreq  = '0;
        m_data  = {D1, D0};
        s_ready = 1'b0;
        s_rdata = '0;
        s_resp  = 1'b0;
        repeat (2) @(negedge clk);
        m_valid = 2'b11;
        s_ready = 1'b1;
        s_resp  = 1'b1;
        #1;
        check("reset grant",   32'(grant),   32'h0);
        check("reset busy",    32'(busy),    32'h0);
        check("reset s_valid", 32'(s_valid), 32'h0);
        check("reset m_ready", 32'(m_ready), 32'h0);
        check("reset m_resp",  32'(m_resp),  32'h0);
        check("reset s_mreq",  32'(s_mreq),  32'h0);
        check("reset s_data",  s_data,       32'h0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            m_valid = vecs[i].valid;
            m_mreq  = vecs[i].mreq;
            s_ready = vecs[i].ready;
            s_resp  = vecs[i].resp;
            s_rdata = vecs[i].rdata;
            #2;
            check($sformatf("v%0d grant", i),   32'(grant),   32'(vecs[i].e_grant));
            check($sformatf("v%0d busy", i),    32'(busy),    32'(vecs[i].e_busy));
            check($sformatf("v%0d s_valid", i), 32'(s_valid), 32'(vecs[i].e_s_valid));
            check($sformatf("v%0d m_ready", i), 32'(m_ready), 32'(vecs[i].e_m_ready));
            check($sformatf("v%0d m_resp", i),  32'(m_resp),  32'(vecs[i].e_m_resp));
            check($sformatf("v%0d s_mreq", i),  32'(s_mreq),  32'(vecs[i].e_s_mreq));
            check($sformatf("v%0d s_data", i),  s_data,       vecs[i].e_s_data);
            check($sformatf("v%0d m_data", i),  m_rdata,      vecs[i].rdata);
            check($sformatf("v%0d l1 s_mreq", i), 32'(l1_s_mreq), 32'h0);
        end

        // Last vector left m0 requesting in ARB with the slave stalled.
        @(posedge clk);
        #2;
        check("pre-reset grant",   32'(grant),   32'h1);
        check("pre-reset s_valid", 32'(s_valid), 32'h1);
        rstn = 1'b0;
        #1;
        check("mid reset s_valid", 32'(s_valid), 32'h0);
        check("mid reset grant",   32'(grant),   32'h0);
        check("mid reset busy",    32'(busy),    32'h0);
        check("mid reset s_data",  s_data,       32'h0);
        repeat (2) @(negedge clk);
        m_valid = 2'b11;
        s_ready = 1'b1;
        rstn    = 1'b1;
        @(posedge clk);
        #2;
        check("post reset grant", 32'(grant), 32'h1);
        check("post reset s_data", s_data, D0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_group_arbiter.md
# bus_group_arbiter

Round-robin arbiter that shares one slave-side valid/ready/data/resp/mreq channel between `N_MST` bus-group masters. It sits between the master instances and the single slave of a bus group. It grants one master at a time and forwards that master's channel to the slave. It honours each master's `mreq` lock request for back-to-back transfers, up to a bounded tenure that prevents starvation.

## Interface
- `N_MST`, 2: number of requesting masters (2..8).
- `DW`, 32: data width.
- `MAX_LOCK`, 16: maximum handshakes per locked tenure (≥1).

- `i_clk`  in  1  clock, rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_m_valid`  in  N_MST  per-master request valid.
- `i_m_data`  in  N_MST*DW  per-master write data; master k occupies bits [k*DW +: DW].
- `i_m_mreq`  in  N_MST  per-master lock request (keep grant after this transfer).
- `o_m_ready`  out  N_MST  handshake accept, owner only.
- `o_m_data`  out  DW  slave read data, broadcast to all masters.
- `o_m_resp`  out  N_MST  response strobe, owner only.
- `o_s_valid`  out  1  valid to slave.
- `i_s_ready`  in  1  slave accept.
- `o_s_data`  out  DW  owner's data to slave.
- `i_s_data`  in  DW  slave read data, valid on the handshake cycle.
- `i_s_resp`  in  1  slave response, valid on the handshake cycle.
- `o_s_mreq`  out  1  lock indication to slave.
- `o_grant`  out  N_MST  one-hot registered owner; all-zero when idle.
- `o_busy`  out  1  high in BUSY state.

## Operation
- States: ARB, BUSY. Registers: `owner` (index), `last` (index of the last owner), `lock_cnt` (width clog2(MAX_LOCK)+1).
- ARB:
  - If any `i_m_valid` bit is high, pick the first requester scanning from `last+1` upward, wrapping modulo N_MST.
  - Register `owner` = winner and `o_grant` = onehot(winner), clear `lock_cnt`, go to BUSY.
  - Outputs are quiet in ARB: `o_s_valid`=0 and `o_m_ready`=0.
- BUSY:
  - `o_s_valid` = `i_m_valid[owner]`; `o_s_data` = owner's slice.
  - `o_s_mreq` = `i_m_mreq[owner]` && (`lock_cnt` < MAX_LOCK-1).
  - `o_m_ready[owner]` = `i_s_ready`.
  - `o_m_resp[owner]` = `i_s_resp` && `i_s_ready` && `i_m_valid[owner]`.
  - Handshake (hs) = `o_s_valid` && `i_s_ready`.
- Transitions out of BUSY:
  - On hs with `o_s_mreq`=1: stay in BUSY and increment `lock_cnt`.
  - On hs with `o_s_mreq`=0 (unlocked, or the MAX_LOCK-th beat): go to ARB, set `last`=owner, clear `o_grant`.
  - If `i_m_valid[owner]`=0 with no hs (owner withdrew, or idle after a locked beat): go to ARB, set `last`=owner. No transfer occurs.
- `o_m_data` = `i_s_data` at all times (combinational passthrough).
- Non-owner `o_m_ready`/`o_m_resp` bits are always 0.
- Data, ready and resp paths are combinational. The only registered decision is the grant.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - state=ARB, `owner`=0, `last`=N_MST-1 (so master 0 wins the first arbitration), `lock_cnt`=0.
  - Outputs: `o_grant`=0, `o_busy`=0, `o_s_valid`=0, `o_s_mreq`=0, `o_m_ready`=0, `o_m_resp`=0, `o_s_data`=0.
- Grant latency: a request seen in ARB at cycle t gives `o_grant` and `o_s_valid` at cycle t+1.
- Unlocked throughput: at most one transfer per 2 cycles (BUSY, ARB, BUSY, …).
- Locked throughput: back-to-back, one transfer per cycle while `i_s_ready`=1, up to MAX_LOCK beats. After the final beat there is one forced ARB cycle.
- Slave back-pressure: BUSY holds indefinitely while `o_s_valid`=1 and `i_s_ready`=0. Masters keep valid and data stable until ready.
- `i_m_mreq` changes mid-tenure take effect on the current cycle's `o_s_mreq`.
- Reset mid-BUSY aborts the transfer immediately. All outputs return to reset values asynchronously.
- Simultaneous requests in ARB: only the round-robin winner is granted. The others wait for the next ARB.
- MAX_LOCK=1: `o_s_mreq` is always 0, so no locking occurs.

## Test plan
- Reset/first grant: release reset, assert valid on m0 and m1 in the same cycle → `o_grant`=01 one cycle later. m0 data 0xA5A5_0001 appears on `o_s_data`; `i_s_ready`=1 gives `o_m_ready`=01. Next ARB grants m1 (`o_grant`=10).
- Round-robin fairness: both masters request continuously, unlocked, with the slave always ready → grants alternate 01,10,01,10. Each transfer takes 2 cycles. No master is ever granted twice in a row.
- Lock and bound (MAX_LOCK=4): m0 holds `i_m_mreq`=1 and valid; m1 also requests → m0 completes 4 consecutive handshakes, with `o_s_mreq`=1 on beats 1–3 and 0 on beat 4. The cycle after beat 4 is ARB, then m1 is granted.
- Back-pressure: m1 granted, `i_s_ready` low for 5 cycles → `o_s_valid` stays 1, `o_m_ready`=00, `o_busy`=1, `o_grant`=10 stable throughout. Ready on cycle 6 completes exactly one transfer. `i_s_resp`=1 gives `o_m_resp`=10 and `o_m_data`=`i_s_data` (e.g. 0x1234_5678).
- Withdrawal and mid-op reset:
  - m0 granted then drops valid before ready → no hs, return to ARB, `last`=0, so m1 wins the next arbitration.
  - Separately, assert `i_rstn`=0 while BUSY with ready low → `o_s_valid` and `o_grant` go to 0 immediately. After release, m0 is granted first.
